// File: rtl/connector_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// connector_pkg : trace-connector field widths and the te_block_t entry
// Rev 1.0
// ------------------------------------------------------------------
package connector_pkg;

  localparam int unsigned XLEN        = 64;
  localparam int unsigned IRETIRE_LEN = 32;
  localparam int unsigned ITYPE_LEN   = 3;
  localparam int unsigned PRIV_LEN    = 2;

  typedef struct packed {
    logic [IRETIRE_LEN-1:0] iretire;
    logic                   ilastsize;
    logic [ITYPE_LEN-1:0]   itype;
    logic [XLEN-1:0]        iaddr;
    logic [XLEN-1:0]        cause;
    logic [XLEN-1:0]        tval;
    logic [PRIV_LEN-1:0]    priv;
  } te_block_t;

endpackage
`default_nettype wire

// File: rtl/te_block_scheduler_if.sv
`default_nettype none
// ------------------------------------------------------------------
// te_block_scheduler_if : connector-side lanes and encoder-side handshake
// Rev 1.0
// ------------------------------------------------------------------
interface te_block_scheduler_if #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
);
  import connector_pkg::*;

  logic [N-1:0]             valid_i;
  logic [N*IRETIRE_LEN-1:0] iretire_i;
  logic [N-1:0]             ilastsize_i;
  logic [N*ITYPE_LEN-1:0]   itype_i;
  logic [N*XLEN-1:0]        iaddr_i;
  logic [XLEN-1:0]          cause_i;
  logic [XLEN-1:0]          tval_i;
  logic [PRIV_LEN-1:0]      priv_i;
  logic                     ready_i;
  logic                     overflow_clr_i;

  logic                     valid_o;
  logic [IRETIRE_LEN-1:0]   iretire_o;
  logic                     ilastsize_o;
  logic [ITYPE_LEN-1:0]     itype_o;
  logic [XLEN-1:0]          iaddr_o;
  logic [XLEN-1:0]          cause_o;
  logic [XLEN-1:0]          tval_o;
  logic [PRIV_LEN-1:0]      priv_o;
  logic                     overflow_o;
  logic [$clog2(DEPTH):0]   occupancy_o;

  modport slave (
    input  valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i,
           cause_i, tval_i, priv_i, ready_i, overflow_clr_i,
    output valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o,
           cause_o, tval_o, priv_o, overflow_o, occupancy_o
  );

  modport master (
    output valid_i, iretire_i, ilastsize_i, itype_i, iaddr_i,
           cause_i, tval_i, priv_i, ready_i, overflow_clr_i,
    input  valid_o, iretire_o, ilastsize_o, itype_o, iaddr_o,
           cause_o, tval_o, priv_o, overflow_o, occupancy_o
  );

endinterface
`default_nettype wire

// File: rtl/te_block_scheduler_compactor.sv
`default_nettype none
// ------------------------------------------------------------------
// te_block_compactor : packs valid lanes, in lane order, into slots 0..k-1
// Rev 1.0
// ------------------------------------------------------------------
module te_block_compactor
  import connector_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]             valid_i,
  input  te_block_t                blocks_i [N],
  output te_block_t                blocks_o [N],
  output logic [$clog2(N+1)-1:0]   k_o
);

  localparam int unsigned KW = $clog2(N + 1);

  logic [KW-1:0] cnt;

  // cnt is the running number of valid lanes below lane i, i.e. lane i's slot.
  always_comb begin
    for (int j = 0; j < N; j++) begin
      blocks_o[j] = '0;
    end
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      if (valid_i[i]) begin
        for (int j = 0; j < N; j++) begin
          if (cnt == KW'(j)) begin
            blocks_o[j] = blocks_i[i];
          end
        end
        cnt = cnt + KW'(1);
      end
    end
    k_o = cnt;
  end

endmodule
`default_nettype wire

// File: rtl/te_block_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// te_block_scheduler : N-lane to single-lane block FIFO with sticky overflow
// Rev 1.0
// ------------------------------------------------------------------
module te_block_scheduler
  import connector_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  te_block_scheduler_if.slave  bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned KW = $clog2(N + 1);

  te_block_t       lane_blk [N];
  te_block_t       comp_blk [N];
  logic [KW-1:0]   k;
  logic [CW-1:0]   k_ext;
  logic [CW-1:0]   free_slots;
  logic            push;
  logic            pop;

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  te_block_t       mem_q [DEPTH];
  te_block_t       head;

  // Shared cause/tval/priv are replicated into every lane's block.
  for (genvar i = 0; i < N; i++) begin : g_lane
    assign lane_blk[i] = '{
      iretire:   bus.iretire_i[i*IRETIRE_LEN +: IRETIRE_LEN],
      ilastsize: bus.ilastsize_i[i],
      itype:     bus.itype_i[i*ITYPE_LEN +: ITYPE_LEN],
      iaddr:     bus.iaddr_i[i*XLEN +: XLEN],
      cause:     bus.cause_i,
      tval:      bus.tval_i,
      priv:      bus.priv_i
    };
  end

  te_block_compactor #(.N(N)) u_compactor (
    .valid_i  (bus.valid_i),
    .blocks_i (lane_blk),
    .blocks_o (comp_blk),
    .k_o      (k)
  );

  // Space is judged on the start-of-cycle count; a concurrent pop frees nothing.
  assign k_ext      = CW'(k);
  assign free_slots = CW'(DEPTH) - count_q;
  assign push       = (k_ext <= free_slots);
  assign pop        = (count_q != '0) && bus.ready_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + k_ext[PW-1:0];
      count_d  = count_d + k_ext;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      count_d  = count_d - CW'(1);
    end
    if (!push) begin
      overflow_d = 1'b1;
    end else if (bus.overflow_clr_i) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int j = 0; j < N; j++) begin
      if (push && (CW'(j) < k_ext)) begin
        mem_q[wr_ptr_q + PW'(j)] <= comp_blk[j];
      end
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.valid_o     = (count_q != '0);
  assign bus.iretire_o   = head.iretire;
  assign bus.ilastsize_o = head.ilastsize;
  assign bus.itype_o     = head.itype;
  assign bus.iaddr_o     = head.iaddr;
  assign bus.cause_o     = head.cause;
  assign bus.tval_o      = head.tval;
  assign bus.priv_o      = head.priv;
  assign bus.overflow_o  = overflow_q;
  assign bus.occupancy_o = count_q;

endmodule
`default_nettype wire

// File: tb/tb_te_block_scheduler.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_te_block_scheduler : directed stimulus, queue-based reference model
// Rev 1.0
// ------------------------------------------------------------------
module tb_te_block_scheduler;
  import connector_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  te_block_scheduler_if #(.N(N), .DEPTH(DEPTH)) bus ();

  te_block_scheduler #(.N(N), .DEPTH(DEPTH)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  te_block_t mq [$];
  te_block_t grp [$];
  bit        mov = 1'b0;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic te_block_t lane_block(int l);
    te_block_t b;
    b.iretire   = bus.iretire_i[l*IRETIRE_LEN +: IRETIRE_LEN];
    b.ilastsize = bus.ilastsize_i[l];
    b.itype     = bus.itype_i[l*ITYPE_LEN +: ITYPE_LEN];
    b.iaddr     = bus.iaddr_i[l*XLEN +: XLEN];
    b.cause     = bus.cause_i;
    b.tval      = bus.tval_i;
    b.priv      = bus.priv_i;
    return b;
  endfunction

  // Reference model: a plain queue, group accepted whole or not at all.
  always @(posedge clk) begin
    if (!rst_n) begin
      mq.delete();
      mov = 1'b0;
    end else begin
      bit fits;
      grp.delete();
      for (int i = 0; i < N; i++)
        if (bus.valid_i[i]) grp.push_back(lane_block(i));
      fits = (grp.size() <= (int'(DEPTH) - mq.size()));
      if (mq.size() != 0 && bus.ready_i) void'(mq.pop_front());
      if (fits) foreach (grp[g]) mq.push_back(grp[g]);
      mov = !fits ? 1'b1 : (bus.overflow_clr_i ? 1'b0 : mov);
    end
  end

  always @(negedge clk) begin
    check("valid_o", 256'(bus.valid_o), 256'(mq.size() != 0));
    check("occupancy_o", 256'(bus.occupancy_o), 256'(mq.size()));
    check("overflow_o", 256'(bus.overflow_o), 256'(mov));
    if (mq.size() != 0)
      check("head", 256'({bus.iretire_o, bus.ilastsize_o, bus.itype_o, bus.iaddr_o,
                          bus.cause_o, bus.tval_o, bus.priv_o}), 256'(mq[0]));
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_lane(int l, logic [63:0] addr, logic [2:0] ty);
    bus.iaddr_i[l*XLEN +: XLEN]               = addr;
    bus.itype_i[l*ITYPE_LEN +: ITYPE_LEN]     = ty;
    bus.iretire_i[l*IRETIRE_LEN +: IRETIRE_LEN] = addr[31:0] + 32'd3;
    bus.ilastsize_i[l]                        = addr[2];
  endtask

  task automatic set_shared(logic [63:0] c, logic [63:0] t, logic [1:0] p);
    bus.cause_i = c;
    bus.tval_i  = t;
    bus.priv_i  = p;
  endtask

  initial begin
    rst_n              = 1'b0;
    bus.valid_i        = '0;
    bus.iretire_i      = '0;
    bus.ilastsize_i    = '0;
    bus.itype_i        = '0;
    bus.iaddr_i        = '0;
    bus.ready_i        = 1'b0;
    bus.overflow_clr_i = 1'b0;
    set_shared(64'h0, 64'h0, 2'd0);

    cyc();
    check("rst valid", 256'(bus.valid_o), 256'(0));
    check("rst occ", 256'(bus.occupancy_o), 256'(0));
    check("rst ovf", 256'(bus.overflow_o), 256'(0));
    cyc();
    rst_n = 1'b1;

    // Ordering
    bus.ready_i = 1'b1;
    set_lane(0, 64'h1000, 3'd1);
    set_lane(1, 64'h2000, 3'd3);
    set_shared(64'h11, 64'h22, 2'd3);
    bus.valid_i = 2'b11;
    cyc();
    bus.valid_i = 2'b00;
    check("ord valid", 256'(bus.valid_o), 256'(1));
    check("ord iaddr0", 256'(bus.iaddr_o), 256'(64'h1000));
    check("ord occ2", 256'(bus.occupancy_o), 256'(2));
    cyc();
    check("ord iaddr1", 256'(bus.iaddr_o), 256'(64'h2000));
    check("ord occ1", 256'(bus.occupancy_o), 256'(1));
    cyc();
    check("ord empty", 256'(bus.valid_o), 256'(0));

    // Gap compaction
    set_lane(0, 64'hDEAD, 3'd7);
    set_lane(1, 64'h3000, 3'd2);
    set_shared(64'h5, 64'h77, 2'd1);
    bus.valid_i = 2'b10;
    cyc();
    bus.valid_i = 2'b00;
    check("gap iaddr", 256'(bus.iaddr_o), 256'(64'h3000));
    check("gap itype", 256'(bus.itype_o), 256'(2));
    check("gap cause", 256'(bus.cause_o), 256'(5));
    check("gap occ", 256'(bus.occupancy_o), 256'(1));
    cyc();

    // Backpressure to full, then drain across the wrap
    bus.ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 64'(8 * c), 3'(c));
      set_lane(1, 64'(8 * c + 4), 3'(c + 1));
      set_shared(64'(c), 64'(100 + c), 2'(c));
      bus.valid_i = 2'b11;
      cyc();
      check("stall head", 256'(bus.iaddr_o), 256'(0));
    end
    bus.valid_i = 2'b00;
    check("full occ", 256'(bus.occupancy_o), 256'(8));
    cyc();
    check("stall hold", 256'(bus.iaddr_o), 256'(0));
    bus.ready_i = 1'b1;
    cyc();
    check("pop occ", 256'(bus.occupancy_o), 256'(7));
    check("pop head", 256'(bus.iaddr_o), 256'(4));
    for (int i = 0; i < 10; i++) begin
      set_lane(0, 64'(32'h100 + 4 * i), 3'(i));
      bus.valid_i = 2'b01;
      cyc();
      check("steady occ", 256'(bus.occupancy_o), 256'(7));
      check("steady head", 256'(bus.iaddr_o),
            256'((i <= 5) ? 4 * (i + 2) : 32'h100 + 4 * (i - 6)));
    end
    bus.valid_i = 2'b00;
    repeat (7) cyc();
    check("drain empty", 256'(bus.valid_o), 256'(0));
    check("drain ovf", 256'(bus.overflow_o), 256'(0));

    // Overflow all-or-nothing at count=7
    bus.ready_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      set_lane(0, 64'(32'h200 + 8 * c), 3'd4);
      set_lane(1, 64'(32'h204 + 8 * c), 3'd5);
      bus.valid_i = (c < 3) ? 2'b11 : 2'b01;
      cyc();
    end
    check("ovf pre occ", 256'(bus.occupancy_o), 256'(7));
    set_lane(0, 64'h900, 3'd6);
    set_lane(1, 64'h904, 3'd6);
    bus.valid_i = 2'b11;
    bus.ready_i = 1'b1;
    cyc();
    check("ovf set", 256'(bus.overflow_o), 256'(1));
    check("ovf occ", 256'(bus.occupancy_o), 256'(6));
    bus.valid_i        = 2'b00;
    bus.ready_i        = 1'b0;
    bus.overflow_clr_i = 1'b1;
    cyc();
    check("ovf clr", 256'(bus.overflow_o), 256'(0));
    bus.overflow_clr_i = 1'b0;

    // Set beats clear
    bus.valid_i = 2'b11;
    cyc();
    check("refill occ", 256'(bus.occupancy_o), 256'(8));
    bus.valid_i        = 2'b01;
    bus.overflow_clr_i = 1'b1;
    cyc();
    check("set>clr", 256'(bus.overflow_o), 256'(1));
    // Full plus ready still overflows
    bus.overflow_clr_i = 1'b0;
    bus.ready_i        = 1'b1;
    cyc();
    check("full+ready occ", 256'(bus.occupancy_o), 256'(7));
    bus.valid_i        = 2'b00;
    bus.ready_i        = 1'b0;
    bus.overflow_clr_i = 1'b1;
    cyc();
    check("clr2", 256'(bus.overflow_o), 256'(0));

    // Reset mid-operation discards contents
    bus.overflow_clr_i = 1'b0;
    bus.valid_i        = 2'b11;
    rst_n              = 1'b0;
    cyc();
    check("mid rst occ", 256'(bus.occupancy_o), 256'(0));
    rst_n       = 1'b1;
    bus.valid_i = 2'b01;
    set_lane(0, 64'h500, 3'd2);
    cyc();
    bus.valid_i = 2'b00;
    check("post rst head", 256'(bus.iaddr_o), 256'(64'h500));
    check("post rst occ", 256'(bus.occupancy_o), 256'(1));
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
